// File: rtl/prog_pkg.sv
// Shared definitions for the program ROM and everything that fetches from it.
package prog_pkg;
  localparam int A_DEF = 10;
  localparam int W_DEF = 9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  localparam logic [A_DEF-1:0] PC_RESET = '0;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, relative branch, absolute branch or increment.
module pc_next_calc #(
  parameter int A     = 10,
  parameter int OFS_W = 8
) (
  input  logic [A-1:0]     pc_i,
  input  logic             hold_i,
  input  logic             branch_en_i,
  input  logic             branch_rel_i,
  input  logic [A-1:0]     target_i,
  input  logic [OFS_W-1:0] offset_i,
  output logic [A-1:0]     pc_next_o
);
  logic [A-1:0] ofs_ext;

  // Offsets are two's complement; sign extension makes backward branches wrap mod 2**A.
  assign ofs_ext = {{(A-OFS_W){offset_i[OFS_W-1]}}, offset_i};

  always_comb begin
    pc_next_o = pc_i + A'(1);
    if (hold_i)
      pc_next_o = pc_i;
    else if (branch_en_i)
      pc_next_o = branch_rel_i ? (pc_i + ofs_ext) : target_i;
  end
endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch FSM driving a combinational instruction ROM.
module inst_fetch
  import prog_pkg::*;
#(
  parameter int A     = A_DEF,
  parameter int W     = W_DEF,
  parameter int OFS_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchRel,
  input  logic [A-1:0]     Target,
  input  logic [OFS_W-1:0] Offset,
  input  logic [W-1:0]     InstIn,
  output logic [A-1:0]     InstAddress,
  output logic [W-1:0]     InstOut,
  output logic             InstValid,
  output logic             Ack,
  output logic [CNT_W-1:0] InstCount
);
  fetch_state_t     state_q, state_d;
  logic [A-1:0]     pc_q, pc_d, pc_nxt;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign InstAddress = pc_q;
  assign InstOut     = InstIn;
  assign InstValid   = (state_q == RUN) && !Stall && !Start;
  assign Ack         = ack_q;
  assign InstCount   = cnt_q;

  // Halt also freezes the PC: the halting instruction stays visible at InstAddress.
  pc_next_calc #(.A(A), .OFS_W(OFS_W)) u_pc_next (
    .pc_i        (pc_q),
    .hold_i      (Stall || Halt),
    .branch_en_i (BranchEn),
    .branch_rel_i(BranchRel),
    .target_i    (Target),
    .offset_i    (Offset),
    .pc_next_o   (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = RUN;
        pc_d    = A'(PC_RESET);
        cnt_d   = '0;
      end
      RUN: if (Start) begin
        pc_d  = A'(PC_RESET);
        cnt_d = '0;
      end else begin
        pc_d = pc_nxt;
        if (InstValid && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (Halt) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end
      end
      DONE: if (Start) begin
        state_d = RUN;
        pc_d    = A'(PC_RESET);
        ack_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= A'(PC_RESET);
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
